// File: rtl/spec_tlb_pkg.sv
// Shared widths, RECV field layout, table depths and walk FSM encoding
// for the page table responder.
package spec_tlb_pkg;

  localparam int VPN8_W   = 6;
  localparam int PPN8_W   = 6;
  localparam int VPN32_W  = 4;
  localparam int PPN32_W  = 4;

  localparam int DEPTH8   = 64;
  localparam int DEPTH32  = 16;

  localparam int RECV8_W        = VPN8_W + PPN8_W;
  localparam int RECV8_PPN_LSB  = 0;
  localparam int RECV8_VPN_LSB  = PPN8_W;
  localparam int RECV32_W       = VPN32_W + PPN32_W;
  localparam int RECV32_PPN_LSB = 0;
  localparam int RECV32_VPN_LSB = PPN32_W;

  localparam int WR_IDX_W = 6;
  localparam int CNT_W    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_e;

  typedef enum logic [0:0] {
    PORT_8B  = 1'b0,
    PORT_32B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/page_table_responder_if.sv
// Request/response and table-write bundle for page_table_responder.
// PAGE_TABLE_FAULT_EN adds the per-port fault strobes.
interface page_table_responder_if;
  import spec_tlb_pkg::*;

  logic                  PAGE_8B_RQST;
  logic [VPN8_W-1:0]     PAGE_8B_LOOKUP;
  logic [RECV8_W-1:0]    PAGE_8B_RECV;
  logic                  PAGE_8B_COMPLETE;
  logic                  PAGE_32B_RQST;
  logic [VPN32_W-1:0]    PAGE_32B_LOOKUP;
  logic [RECV32_W-1:0]   PAGE_32B_RECV;
  logic                  PAGE_32B_COMPLETE;
  logic                  PT_WR_EN;
  logic                  PT_WR_SEL;
  logic [WR_IDX_W-1:0]   PT_WR_IDX;
  logic [PPN8_W-1:0]     PT_WR_PPN;
  logic                  PT_WR_VALID;
`ifdef PAGE_TABLE_FAULT_EN
  logic                  PAGE_8B_FAULT;
  logic                  PAGE_32B_FAULT;
`endif

  modport master (
`ifdef PAGE_TABLE_FAULT_EN
    input  PAGE_8B_FAULT, input PAGE_32B_FAULT,
`endif
    output PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
    output PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
    input  PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE
  );

  modport slave (
`ifdef PAGE_TABLE_FAULT_EN
    output PAGE_8B_FAULT, output PAGE_32B_FAULT,
`endif
    input  PAGE_8B_RQST, PAGE_8B_LOOKUP, PAGE_32B_RQST, PAGE_32B_LOOKUP,
    input  PT_WR_EN, PT_WR_SEL, PT_WR_IDX, PT_WR_PPN, PT_WR_VALID,
    output PAGE_8B_RECV, PAGE_8B_COMPLETE, PAGE_32B_RECV, PAGE_32B_COMPLETE
  );

endinterface

// File: rtl/page_table_responder_array.sv
// page_table_array: one page table, PPN storage in inferred RAM plus a
// resettable valid vector; registered read-first port.
module page_table_array #(
  parameter int DEPTH = 64,
  parameter int PPN_W = 6,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             wr_valid,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PPN_W-1:0] rd_ppn,
  output logic             rd_valid
);

  logic [PPN_W-1:0] mem_reg [DEPTH];
  logic [PPN_W-1:0] rd_ppn_reg;
  logic [DEPTH-1:0] valid_reg;
  logic             rd_valid_reg;

  // A read and write to the same entry on one edge returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_ppn;
    if (rd_en) rd_ppn_reg <= mem_reg[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_en) valid_reg[wr_addr] <= wr_valid;
      if (rd_en) rd_valid_reg <= valid_reg[rd_addr];
    end
  end

  assign rd_ppn   = rd_ppn_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/page_table_responder.sv
// Two-port page table responder: one shared walk engine, fixed LATENCY per
// response. PAGE_TABLE_FAULT_EN reports invalid entries as faults (PPN 0).
module page_table_responder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  page_table_responder_if.slave  bus
);
  import spec_tlb_pkg::*;

  walk_state_e          state_reg, state_next;
  port_sel_e            sel_reg, sel_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 grant8, grant32;

  logic                 slot8_full_reg, slot32_full_reg;
  logic [VPN8_W-1:0]    slot8_vpn_reg;
  logic [VPN32_W-1:0]   slot32_vpn_reg;
  logic [RECV8_W-1:0]   recv8_reg;
  logic [RECV32_W-1:0]  recv32_reg;
  logic                 complete8_reg, complete32_reg;

  logic                 cap8, cap32, avail8, avail32, done, done8, done32;
  logic [VPN8_W-1:0]    lk8;
  logic [VPN32_W-1:0]   lk32;
  logic [PPN8_W-1:0]    rd_ppn8, ppn8_resp;
  logic [PPN32_W-1:0]   rd_ppn32, ppn32_resp;
  logic                 rd_valid8, rd_valid32;

  // A request is only accepted into an empty slot; otherwise it is dropped.
  assign cap8    = bus.PAGE_8B_RQST  & ~slot8_full_reg;
  assign cap32   = bus.PAGE_32B_RQST & ~slot32_full_reg;
  assign avail8  = slot8_full_reg  | bus.PAGE_8B_RQST;
  assign avail32 = slot32_full_reg | bus.PAGE_32B_RQST;
  assign lk8     = slot8_full_reg  ? slot8_vpn_reg  : bus.PAGE_8B_LOOKUP;
  assign lk32    = slot32_full_reg ? slot32_vpn_reg : bus.PAGE_32B_LOOKUP;
  assign done    = (state_reg == ST_WALK) && (cnt_reg == '0);
  assign done8   = done && (sel_reg == PORT_8B);
  assign done32  = done && (sel_reg == PORT_32B);

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    grant8     = 1'b0;
    grant32    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (avail8)       grant8  = 1'b1;
        else if (avail32) grant32 = 1'b1;
      end
      ST_WALK: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = ST_IDLE;
          // Hand the engine straight to the other port for back-to-back service.
          if (sel_reg == PORT_8B) grant32 = avail32;
          else                    grant8  = avail8;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (grant8 || grant32) begin
      state_next = ST_WALK;
      cnt_next   = CNT_W'(LATENCY - 1);
      sel_next   = grant8 ? PORT_8B : PORT_32B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= PORT_8B;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The grant edge is the snapshot: only the granted table performs a read.
  page_table_array #(.DEPTH(DEPTH8), .PPN_W(PPN8_W)) u_table8 (
    .clk(clk), .rst(rst),
    .wr_en(bus.PT_WR_EN & ~bus.PT_WR_SEL), .wr_addr(bus.PT_WR_IDX),
    .wr_ppn(bus.PT_WR_PPN), .wr_valid(bus.PT_WR_VALID),
    .rd_en(grant8), .rd_addr(lk8), .rd_ppn(rd_ppn8), .rd_valid(rd_valid8)
  );

  page_table_array #(.DEPTH(DEPTH32), .PPN_W(PPN32_W)) u_table32 (
    .clk(clk), .rst(rst),
    .wr_en(bus.PT_WR_EN & bus.PT_WR_SEL), .wr_addr(bus.PT_WR_IDX[VPN32_W-1:0]),
    .wr_ppn(bus.PT_WR_PPN[PPN32_W-1:0]), .wr_valid(bus.PT_WR_VALID),
    .rd_en(grant32), .rd_addr(lk32), .rd_ppn(rd_ppn32), .rd_valid(rd_valid32)
  );

`ifdef PAGE_TABLE_FAULT_EN
  logic fault8_reg, fault32_reg;
  assign ppn8_resp  = rd_valid8  ? rd_ppn8  : '0;
  assign ppn32_resp = rd_valid32 ? rd_ppn32 : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      fault8_reg  <= 1'b0;
      fault32_reg <= 1'b0;
    end else begin
      fault8_reg  <= done8  & ~rd_valid8;
      fault32_reg <= done32 & ~rd_valid32;
    end
  end
  assign bus.PAGE_8B_FAULT  = fault8_reg;
  assign bus.PAGE_32B_FAULT = fault32_reg;
`else
  assign ppn8_resp  = rd_valid8  ? rd_ppn8  : slot8_vpn_reg;
  assign ppn32_resp = rd_valid32 ? rd_ppn32 : slot32_vpn_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      slot8_full_reg  <= 1'b0;
      slot32_full_reg <= 1'b0;
      slot8_vpn_reg   <= '0;
      slot32_vpn_reg  <= '0;
      recv8_reg       <= '0;
      recv32_reg      <= '0;
      complete8_reg   <= 1'b0;
      complete32_reg  <= 1'b0;
    end else begin
      slot8_full_reg  <= (slot8_full_reg  & ~done8)  | cap8;
      slot32_full_reg <= (slot32_full_reg & ~done32) | cap32;
      if (cap8)  slot8_vpn_reg  <= bus.PAGE_8B_LOOKUP;
      if (cap32) slot32_vpn_reg <= bus.PAGE_32B_LOOKUP;
      complete8_reg  <= done8;
      complete32_reg <= done32;
      if (done8) begin
        recv8_reg[RECV8_VPN_LSB +: VPN8_W] <= slot8_vpn_reg;
        recv8_reg[RECV8_PPN_LSB +: PPN8_W] <= ppn8_resp;
      end
      if (done32) begin
        recv32_reg[RECV32_VPN_LSB +: VPN32_W] <= slot32_vpn_reg;
        recv32_reg[RECV32_PPN_LSB +: PPN32_W] <= ppn32_resp;
      end
    end
  end

  assign bus.PAGE_8B_RECV      = recv8_reg;
  assign bus.PAGE_8B_COMPLETE  = complete8_reg;
  assign bus.PAGE_32B_RECV     = recv32_reg;
  assign bus.PAGE_32B_COMPLETE = complete32_reg;

endmodule
